// File: rtl/systolic_result_collector.sv
// systolic_result_collector
//   Drain side of the N x N systolic array. Captures the skewed per-column
//   result stream (column j starts j cycles after column 0, rows arrive in
//   order), de-skews it into an N x N buffer and then writes the buffer
//   row-major into the result RAM, one word per cycle.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   start       : begin a capture (honoured only when idle)
//   col_valid   : bit j marks col_data slice j as the next row of column j
//   col_data    : column j result at [j*ACC_W +: ACC_W], two's complement
//   busy        : high while capturing or writing
//   done        : one-cycle pulse after the final RAM write
//   err         : sticky overflow flag, cleared by the next accepted start
//   ram_en/ram_we/ram_addr/ram_di : result RAM write port
//
// Build option
//   COLLECTOR_SATURATE_EN : when defined, ACC_W -> OUT_W conversion
//   saturates signed; otherwise the low OUT_W bits are kept.
module systolic_result_collector #(
    parameter int N     = 4,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N-1:0]         col_valid,
    input  logic [N*ACC_W-1:0]   col_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [OUT_W-1:0]     ram_di
);

    localparam int NN = N * N;
    localparam int CW = $clog2(N + 1);
    localparam int KW = $clog2(NN + 1);
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(N);
    localparam logic [KW-1:0] K_LAST   = KW'(NN - 1);
    localparam logic [KW-1:0] K_FLUSH  = KW'(NN);

    typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q [N];
    logic [CW-1:0]      cnt_d [N];
    logic [KW-1:0]      k_q, k_d;
    logic [OUT_W-1:0]   res_buf_q [NN];
    logic [OUT_W-1:0]   res_buf_d [NN];
    logic [OUT_W-1:0]   conv [N];
    logic [IW-1:0]      wr_idx;
    logic               all_full;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ram_en_q, ram_en_d;
    logic               ram_we_q, ram_we_d;
    logic [AW-1:0]      ram_addr_q, ram_addr_d;
    logic [OUT_W-1:0]   ram_di_q, ram_di_d;

    // Per-column width conversion of the incoming accumulator values.
    always_comb begin
        conv = '{default: '0};
        for (int unsigned j = 0; j < N; j++) begin
`ifdef COLLECTOR_SATURATE_EN
            // Out of range when the bits above the OUT_W sign bit are not
            // all copies of the ACC_W sign bit.
            if (col_data[j*ACC_W+OUT_W-1 +: ACC_W-OUT_W+1] !=
                {(ACC_W-OUT_W+1){col_data[j*ACC_W+ACC_W-1]}})
                conv[j] = col_data[j*ACC_W+ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                    : {1'b0, {(OUT_W-1){1'b1}}};
            else
                conv[j] = col_data[j*ACC_W +: OUT_W];
`else
            conv[j] = col_data[j*ACC_W +: OUT_W];
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        res_buf_d  = res_buf_q;
        err_d      = err_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = '0;
        ram_di_d   = '0;
        wr_idx     = '0;
        all_full   = 1'b1;

        // Outputs are computed for the state being entered so that the
        // registered outputs line up with state_q.
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAPTURE;
                    cnt_d   = '{default: '0};
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            CAPTURE: begin
                busy_d = 1'b1;
                for (int unsigned j = 0; j < N; j++) begin
                    if (col_valid[j]) begin
                        if (cnt_q[j] < CNT_FULL) begin
                            wr_idx = IW'(int'(cnt_q[j]) * N + int'(j));
                            res_buf_d[wr_idx] = conv[j];
                            cnt_d[j] = cnt_q[j] + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (cnt_d[j] != CNT_FULL)
                        all_full = 1'b0;
                end
                if (all_full) begin
                    // First write launches on the same edge as the last
                    // capture, so it reads the buffer's next value.
                    state_d    = WRITE;
                    k_d        = '0;
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = '0;
                    ram_di_d   = res_buf_d[0];
                end
            end
            WRITE: begin
                busy_d = 1'b1;
                if (|col_valid)
                    err_d = 1'b1;
                if (k_q == K_FLUSH) begin
                    // Flush cycle (write port idle) has elapsed.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                    if (k_q != K_LAST) begin
                        ram_en_d   = 1'b1;
                        ram_we_d   = 1'b1;
                        ram_addr_d = AW'(k_d);
                        ram_di_d   = res_buf_q[IW'(k_d)];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            for (int unsigned j = 0; j < N; j++)
                cnt_q[j] <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_di_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        res_buf_q <= res_buf_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign ram_en   = ram_en_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_di   = ram_di_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Self-checking bench for systolic_result_collector (N=4, ACC_W=32,
// OUT_W=16, AW=4). Builds the expected row-major RAM image from the
// column/row placement rules and compares it with the logged RAM writes.
module tb_systolic_result_collector;

    localparam int N     = 4;
    localparam int ACC_W = 32;
    localparam int OUT_W = 16;
    localparam int AW    = 4;

`ifdef COLLECTOR_SATURATE_EN
    localparam logic [15:0] EXP_POS = 16'h7FFF;
    localparam logic [15:0] EXP_NEG = 16'h8000;
`else
    localparam logic [15:0] EXP_POS = 16'h2345;
    localparam logic [15:0] EXP_NEG = 16'h0000;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [N-1:0]         col_valid;
    logic [N*ACC_W-1:0]   col_data;
    logic                 busy, done, err, ram_en, ram_we;
    logic [AW-1:0]        ram_addr;
    logic [OUT_W-1:0]     ram_di;

    systolic_result_collector #(
        .N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .col_valid(col_valid), .col_data(col_data),
        .busy(busy), .done(done), .err(err),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_di(ram_di)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    // RAM write log and done pulses, sampled on the falling edge.
    logic [3:0]  wr_addr [$];
    logic [15:0] wr_data [$];
    int          wr_cyc  [$];
    int          done_cnt;
    int          done_cyc;

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_en && ram_we) begin
                wr_addr.push_back(ram_addr);
                wr_data.push_back(ram_di);
                wr_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Reference model state
    logic [31:0] src [16];
    logic [15:0] exp_img [16];
    int          mcnt [4];
    bit          exp_err;
    int          last_beat_cyc;

    function automatic logic [15:0] conv(input logic [31:0] a);
`ifdef COLLECTOR_SATURATE_EN
        longint s;
        s = longint'($signed(a));
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return a[15:0];
`else
        return a[15:0];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) src[i] = $urandom;
    endtask

    task automatic start_cap();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
        done_cyc = 0;
        for (int j = 0; j < 4; j++) mcnt[j] = 0;
        exp_err = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_cleared_by_start", err, 0);
        chk("no_write_in_capture", ram_en, 0);
    endtask

    // One input cycle; cap=1 means the bench expects the DUT to be capturing.
    task automatic beat(input logic [3:0] v, input logic [127:0] d, input bit cap);
        col_valid = v;
        col_data  = d;
        if (cap) last_beat_cyc = cyc;
        for (int j = 0; j < 4; j++) begin
            if (v[j]) begin
                if (cap && mcnt[j] < 4) begin
                    exp_img[mcnt[j]*4 + j] = conv(d[j*32 +: 32]);
                    mcnt[j]++;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
        tick();
        col_valid = '0;
    endtask

    task automatic run_skewed(input bit extra);
        logic [3:0]   v;
        logic [127:0] d;
        for (int t = 0; t < 7; t++) begin
            v = '0;
            d = '0;
            for (int j = 0; j < 4; j++) begin
                if (t >= j && t <= j + 3) begin
                    v[j] = 1'b1;
                    d[j*32 +: 32] = src[(t-j)*4 + j];
                end
            end
            if (extra && t == 6) begin
                v[2] = 1'b1;
                d[64 +: 32] = 32'h0000_DEAD;
            end
            beat(v, d, 1'b1);
        end
    endtask

    task automatic run_simultaneous();
        logic [127:0] d;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) d[j*32 +: 32] = src[r*4 + j];
            beat(4'hF, d, 1'b1);
        end
    endtask

    task automatic verify_image();
        chk("write_count", wr_addr.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < wr_addr.size()) begin
                chk($sformatf("addr[%0d]", i), wr_addr[i], i);
                chk($sformatf("data[%0d]", i), wr_data[i], exp_img[i]);
                chk($sformatf("wr_cycle[%0d]", i), wr_cyc[i] - wr_cyc[0], i);
            end
        end
        if (wr_cyc.size() > 0) begin
            chk("first_write_latency", wr_cyc[0] - last_beat_cyc, 1);
            chk("done_latency", done_cyc - wr_cyc[0], 17);
        end
        chk("done_pulses", done_cnt, 1);
    endtask

    task automatic wait_done(input int poke_start, input int poke_valid);
        bit seen;
        bit busy_drop;
        seen = 1'b0;
        busy_drop = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            start = (i == poke_start);
            if (i == poke_valid) begin
                beat(4'hF, {4{32'h5A5A_A5A5}}, 1'b0);
            end else begin
                tick();
            end
            start = 1'b0;
            if (done) seen = 1'b1;
            else if (!busy) busy_drop = 1'b1;
        end
        chk("done_seen", seen, 1);
        chk("busy_held", busy_drop, 0);
        chk("err_at_done", err, exp_err);
        chk("busy_at_done", busy, 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("err_after_done", err, exp_err);
        tick();
        verify_image();
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        start = 1'b0;
        col_valid = '0;
        col_data = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_di", ram_di, 0);
        rst = 1'b0;
        tick();

        // Skewed drain with directed values 10*row+col+1
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                src[r*4 + c] = 32'(10*r + c + 1);
        start_cap();
        run_skewed(1'b0);
        wait_done(-1, -1);
        tick();

        // Simultaneous arrival, conversion corner values, col_valid during WRITE
        fill_random();
        src[0] = 32'h0001_2345;
        src[1] = 32'hFFFF_0000;
        start_cap();
        run_simultaneous();
        wait_done(-1, 3);
        chk("conv_pos", wr_data[0], EXP_POS);
        chk("conv_neg", wr_data[1], EXP_NEG);
        tick();

        // Overflow: 5th pulse on column 2 during capture
        fill_random();
        start_cap();
        run_skewed(1'b1);
        wait_done(-1, -1);
        tick();

        // Start pulsed mid-WRITE is ignored
        fill_random();
        start_cap();
        run_skewed(1'b0);
        wait_done(5, -1);
        tick();

        // Reset asserted while address 6 is being written
        fill_random();
        start_cap();
        run_simultaneous();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (ram_en && ram_addr == 4'd6) found = 1'b1;
        end
        chk("reached_addr6", found, 1);
        rst = 1'b1;
        #1;
        chk("midrst_ram_en", ram_en, 0);
        chk("midrst_ram_we", ram_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("idle_after_rst_busy", busy, 0);
        chk("idle_after_rst_done", done, 0);

        // Fresh capture after reset
        fill_random();
        start_cap();
        run_simultaneous();
        wait_done(-1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
